// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Multi-cycle ALU placed between decode and writeback. It executes the 6-bit
//   funct code from ALU_Control.
//   - ADD, SUB, OR and unknown codes finish on the accepting edge.
//   - SRL is iterative and shifts one bit per cycle.
//   Operands enter through a valid/ready handshake. The registered result
//   leaves through a second valid/ready handshake.
//
// Parameters
//   DATA_W    operand/result width
//   SHAMT_W   shift-amount width; the shift amount is src2[SHAMT_W-1:0]
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        funct/src1/src2 valid
//   in_ready   out  1        block can accept a new operation (IDLE only)
//   funct      in   6        ALU operation code
//   src1       in   DATA_W   operand A (value shifted for SRL)
//   src2       in   DATA_W   operand B (shift amount for SRL)
//   out_valid  out  1        result/zero/overflow valid
//   out_ready  in   1        consumer takes the result
//   result     out  DATA_W   registered result
//   zero       out  1        registered (result == 0)
//   overflow   out  1        registered signed overflow (ADD/SUB only)
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    localparam logic [5:0] FN_ADD = 6'b001001;
    localparam logic [5:0] FN_SUB = 6'b001010;
    localparam logic [5:0] FN_OR  = 6'b010010;
    localparam logic [5:0] FN_SRL = 6'b100010;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  result_nxt;
    logic               zero_nxt;
    logic               overflow_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  shreg_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] cnt_nxt;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  op_res;
    logic               op_ovf;
    logic [DATA_W-1:0]  shreg_next_bit;

    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] diff;

    // Signed overflow detection. Only the sign bits matter. The wrapped result
    // is compared against the operand signs.
    function automatic logic add_overflow(input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b,
                                          input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic sub_overflow(input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b,
                                          input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // in_ready is gated by rst_n, so it stays low while reset is asserted.
    assign in_ready  = (state == IDLE) & rst_n;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    assign shamt = src2[SHAMT_W-1:0];
    assign op_a  = src1;
    assign op_b  = src2;
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;

    assign shreg_next_bit = shreg >> 1;

    // Single-edge datapath result. It applies only on the accepting edge.
    // For SRL this path is used only when the shift amount is zero, where
    // the shift is a pass-through.
    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        case (funct)
            FN_ADD: begin
                op_res = sum;
                op_ovf = add_overflow(op_a, op_b, sum);
            end
            FN_SUB: begin
                op_res = diff;
                op_ovf = sub_overflow(op_a, op_b, diff);
            end
            FN_OR:   op_res = src1 | src2;
            FN_SRL:  op_res = src1 >> shamt;
            default: op_res = '0;
        endcase
    end

    // Next-state logic and datapath updates. The default is to hold every
    // register, which keeps the output stable while waiting in DONE.
    always_comb begin
        state_nxt    = state;
        result_nxt   = result;
        zero_nxt     = zero;
        overflow_nxt = overflow;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if ((funct == FN_SRL) && (shamt != '0)) begin
                        shreg_nxt = src1;
                        cnt_nxt   = shamt;
                        state_nxt = BUSY;
                    end else begin
                        result_nxt   = op_res;
                        zero_nxt     = (op_res == '0);
                        overflow_nxt = op_ovf;
                        state_nxt    = DONE;
                    end
                end
            end
            BUSY: begin
                shreg_nxt = shreg_next_bit;
                cnt_nxt   = cnt - CNT_ONE;
                // The last shift is written straight into result, so
                // out_valid rises on the edge where cnt reaches zero.
                if (cnt == CNT_ONE) begin
                    result_nxt   = shreg_next_bit;
                    zero_nxt     = (shreg_next_bit == '0);
                    overflow_nxt = 1'b0;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                // No accept on the release edge, because in_ready is low
                // in DONE.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            shreg    <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            result   <= result_nxt;
            zero     <= zero_nxt;
            overflow <= overflow_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule
